// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state type, active-low segment patterns and inactive pin levels
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  // Active-low a..g in [0]..[6]; index 10 is the dash, 11 is all-off
  localparam logic [11:0][6:0] SEG_TAB = {
    7'h7F, 7'h3F, 7'h10, 7'h00, 7'h78, 7'h02,
    7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG_OFF = SEG_TAB[11];
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic DP_OFF = 1'b1;
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    return d > 4'd9 ? SEG_TAB[10] : SEG_TAB[d];
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_slot_timer.sv
// slot_timer: modulo-DIV slot counter flagging the last blank cycle and the slot end
module slot_timer #(
  parameter int DIV = 10,
  parameter int BLANK = 2
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic term,
  output logic blank_end
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign term = cnt == CW'(DIV - 1);
  assign blank_end = cnt == CW'(BLANK - 1);
  always_ff @(posedge clk) begin
    cnt <= (rst || clr || term) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: four-digit multiplexed 7-segment driver with anti-ghost blanking
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ = 27000000,
  parameter int DIGIT_HZ = 1000,
  parameter int BLANK_CYCLES = 270
)(
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        enableIn,
  input  logic [15:0] digitsIn,
  input  logic [3:0]  dpIn,
  input  logic        lzbIn,
  output logic [6:0]  segOut,
  output logic        dpOut,
  output logic [3:0]  anodeOut,
  output logic        frameOut
);
  localparam int DIV = CLK_HZ / DIGIT_HZ;
  state_t st;
  logic [1:0] idx;
  logic [15:0] snap_d;
  logic [3:0] snap_dp;
  logic snap_lzb;
  logic term, blank_end, show, wrap, lz;
  logic [6:0] seg_next;
  slot_timer #(.DIV(DIV), .BLANK(BLANK_CYCLES)) u_timer (
    .clk(clkIn),
    .rst(resetIn),
    .clr(st == IDLE || !enableIn),
    .term(term),
    .blank_end(blank_end)
  );
  // A digit is a leading zero when it and everything above it is zero
  always_comb begin
    show = st == SHOW;
    wrap = show && term && idx == 2'd3;
    lz = snap_lzb && idx != 2'd0 && (snap_d >> {idx, 2'b00}) == 16'd0;
    seg_next = lz ? SEG_OFF : seg_decode(snap_d[{idx, 2'b00} +: 4]);
  end
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      st <= IDLE;
      idx <= '0;
      snap_d <= '0;
      snap_dp <= '0;
      snap_lzb <= 1'b0;
      segOut <= SEG_OFF;
      dpOut <= DP_OFF;
      anodeOut <= AN_OFF;
      frameOut <= 1'b0;
    end else begin
      segOut <= show ? seg_next : SEG_OFF;
      dpOut <= show && snap_dp[idx] ? 1'b0 : DP_OFF;
      anodeOut <= show ? ~(4'b0001 << idx) : AN_OFF;
      frameOut <= wrap && enableIn;
      if (!enableIn) begin
        st <= IDLE;
        idx <= '0;
      end else begin
        if (st == IDLE || wrap) begin
          snap_d <= digitsIn;
          snap_dp <= dpIn;
          snap_lzb <= lzbIn;
        end
        if (st == IDLE) begin
          st <= BLANK;
          idx <= '0;
        end else if (st == BLANK && blank_end) st <= SHOW;
        else if (show && term) begin
          st <= BLANK;
          idx <= idx + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: timeline-position model of the scanned display plus pinned literal checks
module tb_seg7_scan_ctrl;
  localparam int DIV = 10, B = 2, FR = 4 * DIV;
  logic clk = 0, rst = 1, en = 0, lzb = 0;
  logic [15:0] digits = 16'h0;
  logic [3:0] dp = 4'h0;
  logic [6:0] seg;
  logic dp_o, frame;
  logic [3:0] an;
  int total = 0, bad = 0;
  logic run = 0;

  seg7_scan_ctrl #(.CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(B)) dut (
    .clkIn(clk), .resetIn(rst), .enableIn(en), .digitsIn(digits), .dpIn(dp),
    .lzbIn(lzb), .segOut(seg), .dpOut(dp_o), .anodeOut(an), .frameOut(frame)
  );

  always #5 clk = ~clk;

  // Model: m_k counts cycles since the display started; position within the frame decides everything
  int m_k = 0;
  logic m_act = 0, m_lzb = 0;
  logic [15:0] m_d = 16'h0;
  logic [3:0] m_dp = 4'h0;
  logic [6:0] e_seg = 7'h7F;
  logic e_seg_chk = 1;
  logic [3:0] e_an = 4'hF;
  logic e_dp = 1, e_fr = 0;
  int m_pos, m_dig;
  logic m_show;
  logic [3:0] m_val;
  assign m_pos = m_k % FR;
  assign m_dig = m_pos / DIV;
  assign m_show = m_act && (m_pos % DIV) >= B;
  assign m_val = m_d[4*m_dig +: 4];

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return ~7'h3F;
      4'd1: return ~7'h06;
      4'd2: return ~7'h5B;
      4'd3: return ~7'h4F;
      4'd4: return ~7'h66;
      4'd5: return ~7'h6D;
      4'd6: return ~7'h7D;
      4'd7: return ~7'h07;
      4'd8: return ~7'h7F;
      4'd9: return ~7'h6F;
      default: return ~7'h40;
    endcase
  endfunction

  function automatic logic blanked(input int d, input logic [15:0] ds, input logic l);
    if (!l || d == 0) return 1'b0;
    for (int j = d; j < 4; j++) if (ds[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_seg <= 7'h7F; e_seg_chk <= 1; e_an <= 4'hF; e_dp <= 1; e_fr <= 0;
      m_act <= 0; m_k <= 0; m_d <= 0; m_dp <= 0; m_lzb <= 0;
    end else begin
      e_seg <= (m_show && !blanked(m_dig, m_d, m_lzb)) ? glyph(m_val) : 7'h7F;
      e_seg_chk <= !m_act || m_show;
      e_an <= m_show ? ~(4'b0001 << m_dig) : 4'hF;
      e_dp <= !(m_show && m_dp[m_dig]);
      e_fr <= m_act && en && m_pos == FR - 1;
      if (!en) m_act <= 0;
      else if (!m_act) begin
        m_act <= 1; m_k <= 0; m_d <= digits; m_dp <= dp; m_lzb <= lzb;
      end else begin
        m_k <= m_k + 1;
        if ((m_k + 1) % FR == 0) begin
          m_d <= digits; m_dp <= dp; m_lzb <= lzb;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("anode", {3'b0, an}, {3'b0, e_an});
      chk("dp", {6'b0, dp_o}, {6'b0, e_dp});
      chk("frame", {6'b0, frame}, {6'b0, e_fr});
      if (e_seg_chk) chk("seg", seg, e_seg);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    run = 1;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_anode", {3'b0, an}, 7'h0F);
    chk("rst_dp", {6'b0, dp_o}, 7'h01);
    chk("rst_frame", {6'b0, frame}, 7'h00);
    rst = 0; en = 1; digits = 16'h1234;
    cyc(4);
    chk("d0_anode", {3'b0, an}, 7'b0001110);
    chk("d0_four", seg, 7'b0011001);
    cyc(37);
    chk("frame_pulse", {6'b0, frame}, 7'h01);
    chk("d3_anode", {3'b0, an}, 7'b0000111);
    chk("d3_one", seg, 7'b1111001);
    digits = 16'h5678;
    cyc(5);
    chk("no_tear", seg, 7'b0011001);
    cyc(38);
    chk("new_frame_eight", seg, 7'b0000000);
    digits = 16'h0070; lzb = 1;
    cyc(50);
    chk("lzb_d1_anode", {3'b0, an}, 7'b0001101);
    chk("lzb_d1_seven", seg, 7'b1111000);
    cyc(10);
    chk("lzb_d2_anode", {3'b0, an}, 7'b0001011);
    chk("lzb_d2_blank", seg, 7'h7F);
    digits = 16'h0000;
    cyc(20);
    chk("zero_d0", seg, 7'b1000000);
    cyc(10);
    chk("zero_d1_blank", seg, 7'h7F);
    digits = 16'h00AF; dp = 4'b0010; lzb = 0;
    cyc(30);
    chk("dash_d0", seg, 7'b0111111);
    chk("dp_d0_off", {6'b0, dp_o}, 7'h01);
    cyc(8);
    chk("dp_blank_off", {6'b0, dp_o}, 7'h01);
    cyc(2);
    chk("dash_d1", seg, 7'b0111111);
    chk("dp_d1_on", {6'b0, dp_o}, 7'h00);
    cyc(12);
    en = 0;
    cyc(1);
    chk("abort_lag_anode", {3'b0, an}, 7'b0001011);
    cyc(1);
    chk("abort_anode", {3'b0, an}, 7'h0F);
    chk("abort_seg", seg, 7'h7F);
    chk("abort_frame", {6'b0, frame}, 7'h00);
    cyc(5);
    en = 1;
    cyc(4);
    chk("restart_anode", {3'b0, an}, 7'b0001110);
    cyc(36);
    chk("pre_rst_anode", {3'b0, an}, 7'b0000111);
    rst = 1;
    cyc(1);
    chk("rst_mid_frame", {6'b0, frame}, 7'h00);
    chk("rst_mid_anode", {3'b0, an}, 7'h0F);
    chk("rst_mid_seg", seg, 7'h7F);
    rst = 0;
    cyc(4);
    chk("post_rst_anode", {3'b0, an}, 7'b0001110);
    cyc(90);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
